// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the per-axis state enumeration.
package vga_timing_pkg;

  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_ACT   = 640;
  localparam int H_FRONT = 16;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 29;
  localparam int V_ACT   = 480;
  localparam int V_FRONT = 10;
  localparam int CLK_DIV = 4;

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;

  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int H_ACT_END   = H_ACT_START + H_ACT - 1;
  localparam int V_ACT_START = V_SYNC + V_BACK;
  localparam int V_ACT_END   = V_ACT_START + V_ACT - 1;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    BACK   = 2'd1,
    ACTIVE = 2'd2,
    FRONT  = 2'd3
  } axis_state_e;

endpackage

// File: rtl/vga_axis_fsm.sv
// One timing axis: position counter, SYNC/BACK/ACTIVE/FRONT phase FSM and wrap pulse.
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter int SYNC_LEN  = H_SYNC,
  parameter int BACK_LEN  = H_BACK,
  parameter int ACT_LEN   = H_ACT,
  parameter int FRONT_LEN = H_FRONT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_d_o,
  output axis_state_e      state_o,
  output axis_state_e      state_d_o,
  output logic             wrap_o
);

  localparam int TOTAL = SYNC_LEN + BACK_LEN + ACT_LEN + FRONT_LEN;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(SYNC_LEN);
  localparam logic [CNT_W-1:0] ACT_AT   = CNT_W'(SYNC_LEN + BACK_LEN);
  localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(SYNC_LEN + BACK_LEN + ACT_LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  axis_state_e      state_q, state_d, state_exp;

  assign wrap_o = adv_i && (cnt_q == LAST);

  // Phase changes are keyed on the counter value being entered, so the
  // next-state pair can be decoded downstream with zero latency.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (adv_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
      case (state_q)
        SYNC:    if (cnt_d == BACK_AT)  state_d = BACK;
        BACK:    if (cnt_d == ACT_AT)   state_d = ACTIVE;
        ACTIVE:  if (cnt_d == FRONT_AT) state_d = FRONT;
        FRONT:   if (cnt_d == '0)       state_d = SYNC;
        default:                        state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q   <= '0;
      state_q <= SYNC;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    if (cnt_q < BACK_AT)       state_exp = SYNC;
    else if (cnt_q < ACT_AT)   state_exp = BACK;
    else if (cnt_q < FRONT_AT) state_exp = ACTIVE;
    else                       state_exp = FRONT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      assert (state_q == state_exp);
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_d_o   = cnt_d;
  assign state_o   = state_q;
  assign state_d_o = state_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel strobe divider, horizontal and vertical axes,
// registered sync/visible-area decode and line/frame start pulses.
module vga_timing_gen #(
  parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int H_BACK  = vga_timing_pkg::H_BACK,
  parameter int H_ACT   = vga_timing_pkg::H_ACT,
  parameter int H_FRONT = vga_timing_pkg::H_FRONT,
  parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int V_BACK  = vga_timing_pkg::V_BACK,
  parameter int V_ACT   = vga_timing_pkg::V_ACT,
  parameter int V_FRONT = vga_timing_pkg::V_FRONT
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       active,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       line_start,
  output logic       frame_start
);
  import vga_timing_pkg::*;

  localparam logic [9:0] HA_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] VA_START = 10'(V_SYNC + V_BACK);
  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  logic [1:0]  div_q;
  logic [9:0]  h_cnt, h_cnt_d, v_cnt, v_cnt_d;
  axis_state_e h_state, h_state_d, v_state, v_state_d;
  logic        h_wrap, v_wrap, act_d;
  logic        hs_q, vs_q, active_q, line_start_q, frame_start_q;
  logic [9:0]  pix_x_q;
  logic [8:0]  pix_y_q;

  assign pix_en = (div_q == DIV_LAST);

  vga_axis_fsm #(
    .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK), .ACT_LEN(H_ACT), .FRONT_LEN(H_FRONT)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .adv_i(pix_en),
    .cnt_o(h_cnt), .cnt_d_o(h_cnt_d), .state_o(h_state), .state_d_o(h_state_d),
    .wrap_o(h_wrap)
  );

  vga_axis_fsm #(
    .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK), .ACT_LEN(V_ACT), .FRONT_LEN(V_FRONT)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .adv_i(h_wrap),
    .cnt_o(v_cnt), .cnt_d_o(v_cnt_d), .state_o(v_state), .state_d_o(v_state_d),
    .wrap_o(v_wrap)
  );

  assign act_d = (h_state_d == ACTIVE) && (v_state_d == ACTIVE);

  // Decoded from next-state values so they line up with hcount/vcount.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      div_q         <= '0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      active_q      <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_q + 2'd1;
      hs_q          <= (h_state_d != SYNC);
      vs_q          <= (v_state_d != SYNC);
      active_q      <= act_d;
      pix_x_q       <= act_d ? h_cnt_d - HA_START : '0;
      pix_y_q       <= act_d ? 9'(v_cnt_d - VA_START) : '0;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

  assign hcount      = h_cnt;
  assign vcount      = v_cnt;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign active      = active_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size and shrunken-timing instances checked
// every cycle against an arithmetic model of elapsed clocks since reset.
module tb_vga_timing_gen;

  localparam int S_HS = 4, S_HB = 3, S_HA = 10, S_HF = 2;
  localparam int S_VS = 2, S_VB = 2, S_VA = 5,  S_VF = 2;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       act;
    logic [9:0] px;
    logic [8:0] py;
    logic       ls;
    logic       fs;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       b_pix_en, b_hs, b_vs, b_active, b_ls, b_fs;
  logic [9:0] b_h, b_v, b_px;
  logic [8:0] b_py;
  logic       s_pix_en, s_hs, s_vs, s_active, s_ls, s_fs;
  logic [9:0] s_h, s_v, s_px;
  logic [8:0] s_py;

  vga_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .pix_en(b_pix_en), .hcount(b_h), .vcount(b_v),
    .vga_hs(b_hs), .vga_vs(b_vs), .active(b_active), .pix_x(b_px), .pix_y(b_py),
    .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_SYNC(S_HS), .H_BACK(S_HB), .H_ACT(S_HA), .H_FRONT(S_HF),
    .V_SYNC(S_VS), .V_BACK(S_VB), .V_ACT(S_VA), .V_FRONT(S_VF)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pix_en(s_pix_en), .hcount(s_h), .vcount(s_v),
    .vga_hs(s_hs), .vga_vs(s_vs), .active(s_active), .pix_x(s_px), .pix_y(s_py),
    .line_start(s_ls), .frame_start(s_fs)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  bit armed = 1'b0;
  int phase = 0;
  int hs_low_pe = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d after reset)", name, got, exp, cyc_n);
    end
  endtask

  // Behavioural reference: everything follows from clocks elapsed since reset.
  function automatic exp_t model(input int n, input int hsy, input int hbk, input int hac,
                                 input int hfr, input int vsy, input int vbk, input int vac,
                                 input int vfr);
    exp_t e;
    int ht, vt, p, h, v, has, hae, vas, vae;
    ht  = hsy + hbk + hac + hfr;
    vt  = vsy + vbk + vac + vfr;
    p   = n / 4;
    h   = p % ht;
    v   = (p / ht) % vt;
    has = hsy + hbk;
    hae = has + hac - 1;
    vas = vsy + vbk;
    vae = vas + vac - 1;
    e.pix_en = ((n % 4) == 3);
    e.h      = 10'(h);
    e.v      = 10'(v);
    e.hs     = !(h < hsy);
    e.vs     = !(v < vsy);
    e.act    = (h >= has) && (h <= hae) && (v >= vas) && (v <= vae);
    e.px     = e.act ? 10'(h - has) : 10'd0;
    e.py     = e.act ? 9'(v - vas) : 9'd0;
    e.ls     = (n > 0) && ((n % 4) == 0) && (h == 0);
    e.fs     = e.ls && (v == 0);
    return e;
  endfunction

  task automatic cmp_inst(input string t, input exp_t e, input logic pe, input logic [9:0] h,
                          input logic [9:0] v, input logic hs, input logic vs, input logic act,
                          input logic [9:0] px, input logic [8:0] py, input logic ls,
                          input logic fs);
    chk({t, "_pix_en"}, 32'(pe), 32'(e.pix_en));
    chk({t, "_hcount"}, 32'(h), 32'(e.h));
    chk({t, "_vcount"}, 32'(v), 32'(e.v));
    chk({t, "_vga_hs"}, 32'(hs), 32'(e.hs));
    chk({t, "_vga_vs"}, 32'(vs), 32'(e.vs));
    chk({t, "_active"}, 32'(act), 32'(e.act));
    chk({t, "_pix_x"}, 32'(px), 32'(e.px));
    chk({t, "_pix_y"}, 32'(py), 32'(e.py));
    chk({t, "_line_start"}, 32'(ls), 32'(e.ls));
    chk({t, "_frame_start"}, 32'(fs), 32'(e.fs));
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      cyc_n <= 0;
      armed <= 1'b1;
    end else begin
      cyc_n <= cyc_n + 1;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (armed) begin
      cmp_inst("big", model(cyc_n, 96, 48, 640, 16, 2, 29, 480, 10),
               b_pix_en, b_h, b_v, b_hs, b_vs, b_active, b_px, b_py, b_ls, b_fs);
      cmp_inst("small", model(cyc_n, S_HS, S_HB, S_HA, S_HF, S_VS, S_VB, S_VA, S_VF),
               s_pix_en, s_h, s_v, s_hs, s_vs, s_active, s_px, s_py, s_ls, s_fs);
    end
  end

  // Hand-computed points along the first uninterrupted run after reset.
  always @(negedge clk) begin
    if (phase == 1) begin
      if (cyc_n < 3200 && b_pix_en && !b_hs) hs_low_pe++;
      if (b_ls) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL big_line_start_extra: got pulse at cycle %0d, expected none", cyc_n);
        end else begin
          chk("big_line_start_time", 32'(cyc_n), exp_q.pop_front());
        end
      end
      case (cyc_n)
        2:    chk("lit_pix_en_c3", 32'(b_pix_en), 0);
        3:    begin chk("lit_pix_en_c4", 32'(b_pix_en), 1); chk("lit_h_c4", 32'(b_h), 0); end
        4:    begin chk("lit_pix_en_c5", 32'(b_pix_en), 0); chk("lit_h_c5", 32'(b_h), 1); end
        380:  chk("lit_hs_h95", 32'(b_hs), 0);
        384:  chk("lit_hs_h96", 32'(b_hs), 1);
        3199: begin chk("lit_h799", 32'(b_h), 799); chk("lit_ls_h799", 32'(b_ls), 0); end
        3200: begin
          chk("lit_v1", 32'(b_v), 1);
          chk("lit_hs_line2", 32'(b_hs), 0);
          chk("lit_fs_line2", 32'(b_fs), 0);
          chk("lit_hs_low_pix_periods", 32'(hs_low_pe), 96);
        end
        6400: chk("lit_v2", 32'(b_v), 2);
        151:  chk("lit_s_vs_line1", 32'(s_vs), 0);
        152:  chk("lit_s_vs_line2", 32'(s_vs), 1);
        332:  begin
          chk("lit_s_first_act", 32'(s_active), 1);
          chk("lit_s_first_h", 32'(s_h), 7);
          chk("lit_s_first_v", 32'(s_v), 4);
          chk("lit_s_first_px", 32'(s_px), 0);
          chk("lit_s_first_py", 32'(s_py), 0);
        end
        328:  chk("lit_s_before_act", 32'(s_active), 0);
        672:  begin
          chk("lit_s_last_act", 32'(s_active), 1);
          chk("lit_s_last_px", 32'(s_px), 9);
          chk("lit_s_last_py", 32'(s_py), 4);
        end
        676:  chk("lit_s_after_last_h", 32'(s_active), 0);
        712:  chk("lit_s_after_last_v", 32'(s_active), 0);
        835:  chk("lit_s_fs_pre", 32'(s_fs), 0);
        836:  chk("lit_s_fs_1", 32'(s_fs), 1);
        1672: chk("lit_s_fs_2", 32'(s_fs), 1);
        default: ;
      endcase
    end
  end

  // driver tasks
  task automatic pulse_reset(input int k);
    rst_n = 1'b1;
    repeat (k) @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  task automatic run_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    exp_q.push_back(32'd3200);
    exp_q.push_back(32'd6400);
    pulse_reset(3);
    phase = 1;
    run_cycles(7000);
    phase = 2;
    chk("big_line_start_missing", 32'(exp_q.size()), 0);

    // Mid-line reset on the full-size instance.
    k = 0;
    while (b_h != 10'd500 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_h500", 32'(b_h), 500);
    pulse_reset(1);
    @(negedge clk);
    chk("rst_mid_h", 32'(b_h), 0);
    chk("rst_mid_v", 32'(b_v), 0);
    chk("rst_mid_hs", 32'(b_hs), 0);
    chk("rst_mid_active", 32'(b_active), 0);
    chk("rst_mid_ls", 32'(b_ls), 0);
    chk("rst_mid_pix_en", 32'(b_pix_en), 0);

    k = 0;
    while (!s_fs && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("s_first_frame_after_rst", 32'(cyc_n), 836);

    for (int i = 0; i < 12; i++) begin
      run_cycles($urandom_range(20, 2500));
      pulse_reset($urandom_range(1, 4));
    end
    run_cycles(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be: H_SYNC 96, H_BACK 48, H_ACT 640, H_FRONT 16, V_SYNC 2, V_BACK 29, V_ACT 480, V_FRONT 10, CLK_DIV 4 (clk cycles per pixel).
REQ-002 clk  input  1  system clock; single clock domain; all logic on rising edge.
REQ-003 rst_n  input  1  synchronous, active-high reset.
REQ-004 pix_en  output  1  pixel strobe, high one clk cycle in every CLK_DIV.
REQ-005 hcount  output  10  horizontal pixel counter, 0..799.
REQ-006 vcount  output  10  vertical line counter, 0..520.
REQ-007 vga_hs  output  1  horizontal sync, active low.
REQ-008 vga_vs  output  1  vertical sync, active low.
REQ-009 active  output  1  visible-area flag.
REQ-010 pix_x  output  10  visible column, 0..639; 0 outside the visible area.
REQ-011 pix_y  output  9  visible row, 0..479; 0 outside the visible area.
REQ-012 line_start  output  1  one-clk pulse on the hcount wrap.
REQ-013 frame_start  output  1  one-clk pulse on the frame wrap.

Function
REQ-014 A 2-bit divider SHALL increment every clk and wrap 3->0; pix_en SHALL equal (div==3).
REQ-015 hcount SHALL advance only on edges where pix_en=1, and SHALL wrap 799->0 (H_TOTAL = sum of H_* = 800).
REQ-016 vcount SHALL advance only on edges where pix_en=1 and hcount==799, and SHALL wrap 520->0 (V_TOTAL = 521).
REQ-017 Each axis SHALL run an FSM with states SYNC->BACK->ACTIVE->FRONT->SYNC.
REQ-018 Horizontal state transitions SHALL occur at hcount entry values 0/96/144/784; vertical at vcount entry values 0/2/31/511.
REQ-019 Axis FSM state SHALL always agree with its counter value; any mismatch is a design error, checked by assertion.
REQ-020 vga_hs SHALL be 0 exactly when hcount<96, and vga_vs SHALL be 0 exactly when vcount<2.
REQ-021 active SHALL be 1 exactly when both FSMs are in ACTIVE: hcount 144..783 and vcount 31..510.
REQ-022 When active=1, pix_x SHALL equal hcount-144 and pix_y SHALL equal vcount-31, truncated to their port widths.
REQ-023 vga_hs, vga_vs, active, pix_x and pix_y SHALL be registered and decoded from next-state counter values, so they are valid in the same cycle as the hcount/vcount they describe (zero relative latency).
REQ-024 line_start SHALL be 1 for exactly the clk cycle following an edge where hcount goes 799->0.
REQ-025 frame_start SHALL be 1 for exactly the clk cycle following an edge where (hcount,vcount) goes (799,520)->(0,0); it coincides with line_start.
REQ-026 Counters SHALL hold their values in all cycles with pix_en=0.

Reset
REQ-027 While rst_n=1 at an edge, the block SHALL set div, hcount and vcount to 0 and both FSMs to SYNC.
REQ-028 On the same edge, vga_hs, vga_vs, active, pix_x, pix_y, line_start, frame_start and pix_en SHALL all be 0.
REQ-029 Reset asserted mid-frame SHALL take effect at the next edge, with no partial-line completion.
REQ-030 After reset release, the first pix_en SHALL occur in the 4th clk cycle.
REQ-031 No pulse SHALL be generated by reset release itself: frame_start and line_start stay 0 until the first real wrap.

Structure
REQ-032 Package vga_timing_pkg SHALL hold the timing constants, derived H_TOTAL/V_TOTAL and the boundary constants: H_ACT_START 144, H_ACT_END 783, V_ACT_START 31, V_ACT_END 510.
REQ-033 vga_timing_pkg SHALL also hold the axis state enumeration (SYNC, BACK, ACTIVE, FRONT).
REQ-034 One sub-module, vga_axis_fsm, SHALL contain a counter plus its state FSM and a wrap pulse; it SHALL be instantiated twice (horizontal and vertical).
REQ-035 The vertical vga_axis_fsm instance SHALL be advanced by the horizontal instance's wrap pulse.

Verification
REQ-036 Reset 3 cycles, release -> pix_en high at clk cycles 4, 8, 12, ...; hcount increments once per pix_en.
REQ-037 Run 2 lines -> vga_hs low for 96 pix_en periods; hs period 800 pix_en (3200 clk); line_start pulses 3200 clk apart.
REQ-038 Run 1 frame -> vga_vs low for 2 lines; frame_start period 416800 pix_en (1667200 clk).
REQ-039 Active-window check -> first active at (144,31) with pix_x=0, pix_y=0; last active at (783,510) with pix_x=639, pix_y=479; active=0 at (784,510) and at (144,511).
REQ-040 Assert rst_n at hcount=500, vcount=200 for 1 cycle -> all outputs 0 next cycle; counting restarts from (0,0); no frame_start until a full 1667200-clk frame has elapsed.
